// File: rtl/stream_demux2_pkg.sv
// stream_demux2_pkg: skid buffer state encoding and depth shared by the demux blocks
package stream_demux2_pkg;
  typedef enum logic [1:0] {BUF_EMPTY = 2'd0, BUF_ONE = 2'd1, BUF_TWO = 2'd2} buf_state_t;
  localparam int BUF_DEPTH = 2;
endpackage

// File: rtl/stream_demux2_skid_buf.sv
// stream_demux2_skid_buf: 2-entry FIFO skid buffer, head entry drives data
module stream_demux2_skid_buf
  import stream_demux2_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             valid,
  output logic [WIDTH-1:0] data
);
  buf_state_t state, state_nxt;
  logic [WIDTH-1:0] mem [BUF_DEPTH];
  always_ff @(posedge clk) begin
    if (rst) state <= BUF_EMPTY;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    state_nxt = (push && !pop) ? (state == BUF_EMPTY ? BUF_ONE : BUF_TWO) :
                (pop && !push) ? (state == BUF_TWO ? BUF_ONE : BUF_EMPTY) : state;
  end
  always_ff @(posedge clk) begin
    if (push && (state == BUF_EMPTY || (state == BUF_ONE && pop))) mem[0] <= push_data;
    else if (pop && state == BUF_TWO) mem[0] <= mem[1];
    if (push && !pop && state == BUF_ONE) mem[1] <= push_data;
  end
  assign full  = state == BUF_TWO;
  assign valid = state != BUF_EMPTY;
  assign data  = mem[0];
endmodule

// File: rtl/stream_demux2.sv
// stream_demux2: registered 1:2 stream demux (sel=1 -> out1) with per-output skid buffers; STREAM_DEMUX2_COUNT_EN adds beat counters
module stream_demux2
  import stream_demux2_pkg::*;
#(
  parameter int WIDTH     = 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out2_valid,
  input  logic             out2_ready,
  output logic [WIDTH-1:0] out2_data
`ifdef STREAM_DEMUX2_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0] out1_count,
  output logic [CNT_WIDTH-1:0] out2_count
`endif
);
  logic full1, full2, push1, push2, pop1, pop2;
  assign in_ready = !rst && (in_sel ? !full1 : !full2);
  assign push1    = in_valid && in_ready && in_sel;
  assign push2    = in_valid && in_ready && !in_sel;
  assign pop1     = out1_valid && out1_ready;
  assign pop2     = out2_valid && out2_ready;
  stream_demux2_skid_buf #(.WIDTH(WIDTH)) u_buf1 (
    .clk       (clk),
    .rst       (rst),
    .push      (push1),
    .pop       (pop1),
    .push_data (in_data),
    .full      (full1),
    .valid     (out1_valid),
    .data      (out1_data)
  );
  stream_demux2_skid_buf #(.WIDTH(WIDTH)) u_buf2 (
    .clk       (clk),
    .rst       (rst),
    .push      (push2),
    .pop       (pop2),
    .push_data (in_data),
    .full      (full2),
    .valid     (out2_valid),
    .data      (out2_data)
  );
`ifdef STREAM_DEMUX2_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      out1_count <= '0;
      out2_count <= '0;
    end else begin
      out1_count <= out1_count + CNT_WIDTH'(pop1);
      out2_count <= out2_count + CNT_WIDTH'(pop2);
    end
  end
`else
  logic [CNT_WIDTH-1:0] unused_cnt;
  assign unused_cnt = '0;
`endif
endmodule

// File: tb/tb_stream_demux2.sv
// tb_stream_demux2: vector table, hand sequences and queue-model random run for stream_demux2
module tb_stream_demux2;
  localparam int W  = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, in_sel, out1_valid, out1_ready, out2_valid, out2_ready;
  logic [W-1:0] in_data, out1_data, out2_data;
`ifdef STREAM_DEMUX2_COUNT_EN
  logic [CW-1:0] out1_count, out2_count;
`endif

  always #5 clk = ~clk;

  stream_demux2 #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_data    (in_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .out2_valid (out2_valid),
    .out2_ready (out2_ready),
    .out2_data  (out2_data)
`ifdef STREAM_DEMUX2_COUNT_EN
    ,
    .out1_count (out1_count),
    .out2_count (out2_count)
`endif
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int rst, iv, sel, d, r1, r2, ir, v1, d1, v2, d2;
  } vec_t;
  vec_t tbl [18];

  logic [W-1:0] q1 [$];
  logic [W-1:0] q2 [$];
  int c1, c2;
  logic exp_ir;

  initial begin
    tbl = '{
      // rst iv sel d     r1 r2 ir v1 d1    v2 d2
      '{1, 1, 1, 'hFF, 1, 1, 0, 0, 0,    0, 0},
      '{1, 1, 1, 'hFF, 1, 1, 0, 0, 0,    0, 0},
      '{1, 1, 1, 'hFF, 1, 1, 0, 0, 0,    0, 0},
      '{0, 1, 1, 'hA5, 1, 1, 1, 0, 0,    0, 0},
      '{0, 1, 0, 'h3C, 1, 1, 1, 1, 'hA5, 0, 0},
      '{0, 0, 0, 'h00, 1, 1, 1, 0, 0,    1, 'h3C},
      '{0, 0, 1, 'h00, 0, 1, 1, 0, 0,    0, 0},
      '{0, 1, 1, 'h01, 0, 1, 1, 0, 0,    0, 0},
      '{0, 1, 1, 'h02, 0, 1, 1, 1, 'h01, 0, 0},
      '{0, 1, 1, 'h03, 0, 1, 0, 1, 'h01, 0, 0},
      '{0, 1, 1, 'h03, 0, 1, 0, 1, 'h01, 0, 0},
      '{0, 1, 0, 'h10, 0, 1, 1, 1, 'h01, 0, 0},
      '{0, 1, 1, 'h03, 0, 1, 0, 1, 'h01, 1, 'h10},
      '{0, 1, 1, 'h03, 1, 1, 0, 1, 'h01, 0, 0},
      '{0, 1, 1, 'h03, 1, 1, 1, 1, 'h02, 0, 0},
      '{0, 1, 1, 'h04, 1, 1, 1, 1, 'h03, 0, 0},
      '{0, 0, 1, 'h00, 1, 1, 1, 1, 'h04, 0, 0},
      '{0, 0, 1, 'h00, 1, 1, 1, 0, 0,    0, 0}
    };
    rst = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
    out1_ready = 1'b1; out2_ready = 1'b1;
    cyc();

    for (int i = 0; i < 18; i++) begin
      rst        = tbl[i].rst[0];
      in_valid   = tbl[i].iv[0];
      in_sel     = tbl[i].sel[0];
      in_data    = tbl[i].d[W-1:0];
      out1_ready = tbl[i].r1[0];
      out2_ready = tbl[i].r2[0];
      #1;
      chk($sformatf("vec%0d in_ready", i), 32'(in_ready), tbl[i].ir);
      chk($sformatf("vec%0d out1_valid", i), 32'(out1_valid), tbl[i].v1);
      chk($sformatf("vec%0d out2_valid", i), 32'(out2_valid), tbl[i].v2);
      if (tbl[i].v1 != 0) chk($sformatf("vec%0d out1_data", i), 32'(out1_data), tbl[i].d1);
      if (tbl[i].v2 != 0) chk($sformatf("vec%0d out2_data", i), 32'(out2_data), tbl[i].d2);
`ifdef STREAM_DEMUX2_COUNT_EN
      if (tbl[i].rst != 0) begin
        chk($sformatf("vec%0d out1_count", i), 32'(out1_count), 0);
        chk($sformatf("vec%0d out2_count", i), 32'(out2_count), 0);
      end
`endif
      cyc();
    end

    rst = 1'b0; in_valid = 1'b1; in_sel = 1'b1; in_data = 8'hAA; out1_ready = 1'b0; out2_ready = 1'b1;
    #1; chk("mid push aa", 32'(in_ready), 1); cyc();
    in_data = 8'hBB;
    #1; chk("mid push bb", 32'(in_ready), 1); chk("mid head aa", 32'(out1_data), 32'hAA); cyc();
    in_data = 8'hCC;
    #1; chk("mid full stall", 32'(in_ready), 0); cyc();
    rst = 1'b1;
    #1; chk("mid rst in_ready", 32'(in_ready), 0); cyc();
    rst = 1'b0; in_valid = 1'b0;
    #1; chk("mid rst out1_valid", 32'(out1_valid), 0); chk("mid rst out2_valid", 32'(out2_valid), 0);
    in_valid = 1'b1; in_data = 8'hDD; out1_ready = 1'b1;
    #1; chk("post rst accept", 32'(in_ready), 1); cyc();
    in_valid = 1'b0;
    #1; chk("post rst out1_valid", 32'(out1_valid), 1); chk("post rst out1_data", 32'(out1_data), 32'hDD); cyc();
    #1; chk("post rst drained", 32'(out1_valid), 0);

    rst = 1'b1; cyc();
    rst = 1'b0; in_valid = 1'b1; in_sel = 1'b0; out1_ready = 1'b1; out2_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_data = 8'(i + 'h40);
      #1;
      chk($sformatf("cnt beat%0d in_ready", i), 32'(in_ready), 1);
      if (i > 0) chk($sformatf("cnt beat%0d out2_data", i), 32'(out2_data), 32'(i - 1 + 'h40));
      chk($sformatf("cnt beat%0d out1_valid", i), 32'(out1_valid), 0);
      cyc();
    end
    in_valid = 1'b0;
    #1; chk("cnt last out2_data", 32'(out2_data), 32'h50); cyc();
    #1; chk("cnt drained", 32'(out2_valid), 0);
`ifdef STREAM_DEMUX2_COUNT_EN
    chk("cnt out2_count wrap", 32'(out2_count), 1);
    chk("cnt out1_count", 32'(out1_count), 0);
`endif

    c1 = 0; c2 = 0;
    for (int n = 0; n < 2000; n++) begin
      rst        = (n == 0) || ($urandom_range(0, 63) == 0);
      in_valid   = 1'($urandom);
      in_sel     = 1'($urandom);
      in_data    = 8'($urandom);
      out1_ready = $urandom_range(0, 3) != 0;
      out2_ready = $urandom_range(0, 2) == 0;
      #1;
      exp_ir = !rst && (in_sel ? q1.size() < 2 : q2.size() < 2);
      if (n > 0) begin
        chk("rnd in_ready", 32'(in_ready), 32'(exp_ir));
        chk("rnd out1_valid", 32'(out1_valid), 32'(q1.size() != 0));
        chk("rnd out2_valid", 32'(out2_valid), 32'(q2.size() != 0));
        if (q1.size() != 0) chk("rnd out1_data", 32'(out1_data), 32'(q1[0]));
        if (q2.size() != 0) chk("rnd out2_data", 32'(out2_data), 32'(q2[0]));
`ifdef STREAM_DEMUX2_COUNT_EN
        chk("rnd out1_count", 32'(out1_count), 32'(c1 % (1 << CW)));
        chk("rnd out2_count", 32'(out2_count), 32'(c2 % (1 << CW)));
`endif
      end
      if (rst) begin
        q1.delete(); q2.delete(); c1 = 0; c2 = 0;
      end else begin
        if (q1.size() != 0 && out1_ready) begin void'(q1.pop_front()); c1++; end
        if (q2.size() != 0 && out2_ready) begin void'(q2.pop_front()); c2++; end
        if (in_valid && exp_ir) begin
          if (in_sel) q1.push_back(in_data);
          else q2.push_back(in_data);
        end
      end
      cyc();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/stream_demux2.md
Name: stream_demux2

Overview:
- Registered 1:2 stream demultiplexer; the inverse of the team's 2:1 mux.
- Steers each valid/ready beat from one input channel to output channel 1 (sel=1) or output channel 2 (sel=0), matching the mux's in1/in2 select polarity.
- Each output has its own 2-entry skid buffer, so a stall on one output never blocks traffic to the other while that other buffer has room.
- Sits between a single producer and two independent consumers on datapath and fabric streams.

Parameters:
- WIDTH, 1, data bits per beat.
- CNT_WIDTH, 16, width of the optional per-output beat counters.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  input beat accepted when in_valid && in_ready.
- in_sel  input  1  destination of the beat: 1 routes to out1, 0 routes to out2. Sampled only on acceptance.
- in_data  input  WIDTH  input payload.
- out1_valid  output  1  out1 beat valid.
- out1_ready  input  1  out1 consumer ready.
- out1_data  output  WIDTH  out1 payload.
- out2_valid  output  1  out2 beat valid.
- out2_ready  input  1  out2 consumer ready.
- out2_data  output  WIDTH  out2 payload.
- out1_count  output  CNT_WIDTH  beats delivered on out1 (present only when the macro is defined).
- out2_count  output  CNT_WIDTH  beats delivered on out2 (present only when the macro is defined).

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: out1_valid=0, out2_valid=0, counters=0. Both buffers go to EMPTY. Data registers are not reset. out*_data are don't-care while out*_valid=0.
- Reset mid-operation drops all buffered beats. No beat is accepted in the reset cycle (in_ready=0 while rst=1).
- Per-output buffer FSM: EMPTY -> ONE -> TWO.
  - Push only: EMPTY->ONE, ONE->TWO.
  - Pop only: TWO->ONE, ONE->EMPTY.
  - Push and pop in the same cycle: ONE stays ONE, TWO stays TWO.
  - Push into TWO is illegal and cannot occur, because in_ready blocks it.
- in_ready = !rst && (in_sel ? buf1!=TWO : buf2!=TWO).
  - Combinational from in_sel and registered state only.
  - Never depends on out*_ready (no ready-to-ready combinational path).
- Push to buffer k = in_valid && in_ready && (in_sel selects k). Exactly one buffer is pushed per accepted beat.
- Pop of buffer k = outk_valid && outk_ready. outk_valid = (bufk != EMPTY).
- Latency: 1 cycle. A beat accepted at edge N is visible on outk at cycle N+1.
- Throughput: 1 beat/cycle sustained to either output while its consumer holds ready=1.
- Ordering: strict FIFO per output. No ordering guarantee across outputs.
- Output stability: while outk_valid=1 && outk_ready=0, outk_data is held stable.
- Full condition: with buffer k in TWO, a beat with in_sel targeting k stalls (in_ready=0). A beat targeting the other output is still accepted, provided that output's buffer is not TWO.
- Simultaneous pop of TWO and push of a new beat to the same buffer: the push is blocked this cycle by the registered state (in_ready=0); the push lands next cycle.
- in_sel or in_data changing while in_valid=1 && in_ready=0 is permitted. Only the values at acceptance matter.

Optional Feature:
- Macro: STREAM_DEMUX2_COUNT_EN.
- Defined:
  - out1_count and out2_count ports exist.
  - Each increments by 1 on every pop of its output.
  - Each wraps modulo 2^CNT_WIDTH (all-ones + 1 -> 0).
  - Each clears on rst.
- Undefined: counter ports and logic are absent. All other behaviour is identical.

Decomposition:
- Package stream_demux2_pkg:
  - typedef enum logic [1:0] buf_state_t {BUF_EMPTY=2'd0, BUF_ONE=2'd1, BUF_TWO=2'd2}.
  - localparam BUF_DEPTH=2.
- One sub-module, stream_demux2_skid_buf (WIDTH parameter): the 2-entry buffer plus FSM, with push/pop/full/valid/data interface.
- Top level instantiates it twice; steering and counters live in the top level.

Test Plan:
- Reset: assert rst for 3 cycles with in_valid=1 -> in_ready=0, out1_valid=0, out2_valid=0, counts=0 throughout.
- Steering and latency (WIDTH=8): send 0xA5 with sel=1, then 0x3C with sel=0, both outputs ready=1 -> out1 shows 0xA5 one cycle after its acceptance; out2 shows 0x3C one cycle after its acceptance; no beat appears on the wrong output.
- Backpressure isolation: out1_ready=0, stream 0x01..0x04 with sel=1, then 0x10 with sel=0 -> first 2 beats accepted, 3rd stalls with in_ready=0. After changing in_sel to 0, 0x10 is accepted and delivered on out2 while out1 holds 0x01 stable.
- Drain order: release out1_ready -> out1 delivers 0x01, 0x02, 0x03, 0x04 in order, one per cycle after the stall clears.
- Reset mid-stream: rst pulsed for 1 cycle while buf1=TWO -> out1_valid=0 next cycle, buffered beats never appear, and a beat sent after reset is delivered normally.
- STREAM_DEMUX2_COUNT_EN with CNT_WIDTH=4: deliver 17 beats to out2 -> out2_count=1 (wrapped) and out1_count=0.
